// File: rtl/amo_sequencer_if.sv
// amo_sequencer_if
// Bundles the execute-side request, the memory-access queue port, and the
// writeback/exception outputs of amo_sequencer.
//   slave  modport : used by amo_sequencer
//   master modport : used by whoever drives the execute/memory side
// Parameters: ADDR_W (address width), DATA_W (data width, 64 expected).
//
// Handshake semantics (request and memory ports alike): a transfer happens on
// a rising clock edge where valid and ready are both 1. While valid is high,
// the payload stays stable and valid is not withdrawn until that transfer.
// Memory responses and the wb/fault outputs are one-cycle pulses without a
// ready.
interface amo_sequencer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Execute-stage request
    logic              i_req_valid;
    logic              o_req_ready;
    logic [3:0]        i_op;
    logic              i_rv32;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rs2;
    logic [5:0]        i_waddr;
    // Memory-access queue
    logic              o_mem_valid;
    logic              i_mem_ready;
    logic              o_mem_write;
    logic [1:0]        o_mem_size;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_resp_valid;
    logic [DATA_W-1:0] i_mem_resp_data;
    logic              i_mem_resp_fault;
    // Writeback / exception
    logic              o_wb_valid;
    logic [5:0]        o_wb_addr;
    logic [DATA_W-1:0] o_wb_data;
    logic              o_fault;
    logic [1:0]        o_fault_code;
    logic [ADDR_W-1:0] o_fault_addr;
    logic              o_busy;

    modport slave (
        input  i_req_valid, i_op, i_rv32, i_addr, i_rs2, i_waddr,
        input  i_mem_ready, i_mem_resp_valid, i_mem_resp_data, i_mem_resp_fault,
        output o_req_ready, o_mem_valid, o_mem_write, o_mem_size, o_mem_addr,
        output o_mem_wdata, o_wb_valid, o_wb_addr, o_wb_data, o_fault,
        output o_fault_code, o_fault_addr, o_busy
    );

    modport master (
        output i_req_valid, i_op, i_rv32, i_addr, i_rs2, i_waddr,
        output i_mem_ready, i_mem_resp_valid, i_mem_resp_data, i_mem_resp_fault,
        input  o_req_ready, o_mem_valid, o_mem_write, o_mem_size, o_mem_addr,
        input  o_mem_wdata, o_wb_valid, o_wb_addr, o_wb_data, o_fault,
        input  o_fault_code, o_fault_addr, o_busy
    );
endinterface

// File: rtl/amo_sequencer.sv
// amo_sequencer
// Multi-cycle sequencer for RISC-V AMO*.W / AMO*.D: load, modify, store, then
// return the original memory value for writeback. One AMO in flight at most.
// Ports:
//   i_clk, i_nrst : clock, asynchronous active-low reset
//   bus           : amo_sequencer_if.slave (request, memory port, wb/fault)
//   o_dbg_state   : current FSM state (state_t encoding)
// Optional feature: define RIVER_AMO_MINMAX_EN to support MIN/MAX/MINU/MAXU
// (ops 5-8). Without it those ops fault as illegal and the comparators are
// not built.
module amo_sequencer #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    amo_sequencer_if.slave       bus,
    output logic [2:0]           o_dbg_state
);
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ       = 3'd1,
        ST_WAIT_READ  = 3'd2,
        ST_MODIFY     = 3'd3,
        ST_WRITE      = 3'd4,
        ST_WAIT_WRITE = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

`ifdef RIVER_AMO_MINMAX_EN
    localparam logic [3:0] MAX_OP = 4'd8;
`else
    localparam logic [3:0] MAX_OP = 4'd4;
`endif

    state_t            state, state_nxt;
    logic [3:0]        op_q;
    logic              rv32_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rs2_q;
    logic [5:0]        waddr_q;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] wdata_q;
    logic              fault_q;
    logic [1:0]        fault_code_q;

    logic              misaligned;
    logic              illegal;
    logic [DATA_W-1:0] opa, opb, res, mem_sext;

    assign misaligned = bus.i_rv32 ? (bus.i_addr[1:0] != 2'b00)
                                   : (bus.i_addr[2:0] != 3'b000);
    assign illegal    = bus.i_op > MAX_OP;

    // State register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (bus.i_req_valid)
                               state_nxt = (misaligned || illegal) ? ST_DONE : ST_READ;
            ST_READ:       if (bus.i_mem_ready) state_nxt = ST_WAIT_READ;
            ST_WAIT_READ:  if (bus.i_mem_resp_valid)
                               state_nxt = bus.i_mem_resp_fault ? ST_DONE : ST_MODIFY;
            ST_MODIFY:     state_nxt = ST_WRITE;
            ST_WRITE:      if (bus.i_mem_ready) state_nxt = ST_WAIT_WRITE;
            ST_WAIT_WRITE: if (bus.i_mem_resp_valid) state_nxt = ST_DONE;
            ST_DONE:       state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // ALU. .W operands are zero-extended words, so the low 32 bits of res are
    // the .W result and ADD wraps correctly once the upper half is dropped.
`ifdef RIVER_AMO_MINMAX_EN
    logic [DATA_W-1:0] opa_s, opb_s;
    logic              lt_s, lt_u;
`endif
    always_comb begin
        opa = rv32_q ? {{(DATA_W-32){1'b0}}, mem_q[31:0]} : mem_q;
        opb = rv32_q ? {{(DATA_W-32){1'b0}}, rs2_q[31:0]} : rs2_q;
`ifdef RIVER_AMO_MINMAX_EN
        // Sign-extended copies let one signed comparator serve both widths.
        opa_s = rv32_q ? {{(DATA_W-32){mem_q[31]}}, mem_q[31:0]} : mem_q;
        opb_s = rv32_q ? {{(DATA_W-32){rs2_q[31]}}, rs2_q[31:0]} : rs2_q;
        lt_s  = $signed(opa_s) < $signed(opb_s);
        lt_u  = opa < opb;
`endif
        case (op_q)
            4'd0:    res = opb;
            4'd1:    res = opa + opb;
            4'd2:    res = opa ^ opb;
            4'd3:    res = opa & opb;
            4'd4:    res = opa | opb;
`ifdef RIVER_AMO_MINMAX_EN
            4'd5:    res = lt_s ? opa : opb;
            4'd6:    res = lt_s ? opb : opa;
            4'd7:    res = lt_u ? opa : opb;
            4'd8:    res = lt_u ? opb : opa;
`endif
            default: res = '0;
        endcase
    end

    // Latched request fields, load data, store data and pending fault
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            op_q         <= '0;
            rv32_q       <= 1'b0;
            addr_q       <= '0;
            rs2_q        <= '0;
            waddr_q      <= '0;
            mem_q        <= '0;
            wdata_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: if (bus.i_req_valid) begin
                    op_q         <= bus.i_op;
                    rv32_q       <= bus.i_rv32;
                    addr_q       <= bus.i_addr;
                    rs2_q        <= bus.i_rs2;
                    waddr_q      <= bus.i_waddr;
                    fault_q      <= misaligned || illegal;
                    // Misalignment wins when a request is both.
                    fault_code_q <= misaligned ? 2'd2 : 2'd3;
                end
                ST_WAIT_READ: if (bus.i_mem_resp_valid) begin
                    mem_q <= bus.i_mem_resp_data;
                    if (bus.i_mem_resp_fault) begin
                        fault_q      <= 1'b1;
                        fault_code_q <= 2'd0;
                    end
                end
                ST_MODIFY:
                    wdata_q <= rv32_q ? {{(DATA_W-32){1'b0}}, res[31:0]} : res;
                ST_WAIT_WRITE: if (bus.i_mem_resp_valid && bus.i_mem_resp_fault) begin
                    fault_q      <= 1'b1;
                    fault_code_q <= 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from registered state only; payloads are zero unless
    // their valid is high, so everything reads 0 in reset.
    assign mem_sext        = rv32_q ? {{(DATA_W-32){mem_q[31]}}, mem_q[31:0]} : mem_q;
    assign bus.o_req_ready = (state == ST_IDLE);
    assign bus.o_busy      = (state != ST_IDLE);
    assign bus.o_mem_valid = (state == ST_READ) || (state == ST_WRITE);
    assign bus.o_mem_write = (state == ST_WRITE);
    assign bus.o_mem_size  = bus.o_mem_valid ? (rv32_q ? 2'd2 : 2'd3) : 2'd0;
    assign bus.o_mem_addr  = bus.o_mem_valid ? addr_q : '0;
    assign bus.o_mem_wdata = (state == ST_WRITE) ? wdata_q : '0;
    assign bus.o_wb_valid  = (state == ST_DONE) && !fault_q && (waddr_q != 6'd0);
    assign bus.o_wb_addr   = bus.o_wb_valid ? waddr_q : 6'd0;
    assign bus.o_wb_data   = bus.o_wb_valid ? mem_sext : '0;
    assign bus.o_fault      = (state == ST_DONE) && fault_q;
    assign bus.o_fault_code = bus.o_fault ? fault_code_q : 2'd0;
    assign bus.o_fault_addr = bus.o_fault ? addr_q : '0;
    assign o_dbg_state      = state;
endmodule

// File: tb/tb_amo_sequencer.sv
module tb_amo_sequencer;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
`ifdef RIVER_AMO_MINMAX_EN
  localparam logic [3:0] MAX_OP = 4'd8;
`else
  localparam logic [3:0] MAX_OP = 4'd4;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_checks;
  int         n_fail;

  amo_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  amo_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk       (clk),
    .i_nrst      (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard queues: store data, {waddr, wb data}, {fault code, address}
  logic [63:0] exp_wd_q[$];
  logic [69:0] exp_wb_q[$];
  logic [65:0] exp_flt_q[$];

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] amo_model(input logic [3:0] op, input logic rv32,
                                            input logic [63:0] m, input logic [63:0] s);
    logic [31:0] a, b, r32;
    logic [63:0] r64;
    a = m[31:0];
    b = s[31:0];
    case (op)
      4'd0: begin r32 = b;     r64 = s;     end
      4'd1: begin r32 = a + b; r64 = m + s; end
      4'd2: begin r32 = a ^ b; r64 = m ^ s; end
      4'd3: begin r32 = a & b; r64 = m & s; end
      4'd4: begin r32 = a | b; r64 = m | s; end
      4'd5: begin r32 = ($signed(a) < $signed(b)) ? a : b; r64 = ($signed(m) < $signed(s)) ? m : s; end
      4'd6: begin r32 = ($signed(a) > $signed(b)) ? a : b; r64 = ($signed(m) > $signed(s)) ? m : s; end
      4'd7: begin r32 = (a < b) ? a : b; r64 = (m < s) ? m : s; end
      4'd8: begin r32 = (a > b) ? a : b; r64 = (m > s) ? m : s; end
      default: begin r32 = '0; r64 = '0; end
    endcase
    return rv32 ? {32'h0, r32} : r64;
  endfunction

  // monitor: pop on first cycle of each store, and on each wb/fault pulse
  logic wr_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_prev = 1'b0;
    end else begin
      if (bus.o_mem_valid && bus.o_mem_write && !wr_prev) begin
        n_checks++;
        assert (exp_wd_q.size() != 0) else begin
          n_fail++; $error("FAIL store_unexpected: observed wdata %h expected no store", bus.o_mem_wdata);
        end
        if (exp_wd_q.size() != 0) check("store_wdata", 70'(bus.o_mem_wdata), 70'(exp_wd_q.pop_front()));
      end
      wr_prev = bus.o_mem_valid && bus.o_mem_write;
      if (bus.o_wb_valid) begin
        n_checks++;
        assert (exp_wb_q.size() != 0) else begin
          n_fail++; $error("FAIL wb_unexpected: observed x%0d=%h expected no writeback", bus.o_wb_addr, bus.o_wb_data);
        end
        if (exp_wb_q.size() != 0) check("wb_addr_data", {bus.o_wb_addr, bus.o_wb_data}, exp_wb_q.pop_front());
      end
      if (bus.o_fault) begin
        n_checks++;
        assert (exp_flt_q.size() != 0) else begin
          n_fail++; $error("FAIL fault_unexpected: observed code %0d addr %h expected no fault", bus.o_fault_code, bus.o_fault_addr);
        end
        if (exp_flt_q.size() != 0) check("fault_code_addr", 70'({bus.o_fault_code, bus.o_fault_addr}), 70'(exp_flt_q.pop_front()));
      end
    end
  end

  // driver: one AMO from handshake (cycle 0) until ready returns; acts as the
  // memory, answering one cycle after each accepted request
  task automatic do_amo(input logic [3:0] op, input logic rv32, input logic [63:0] addr,
                        input logic [63:0] rs2, input logic [5:0] waddr, input logic [63:0] mem,
                        input logic lfault, input logic sfault, input int stall,
                        input logic abort_ww, input logic early_resp);
    logic early, misal, pend, pend_fault, pend_wr, done, exp_pulse;
    logic [63:0] pend_data;
    int cyc, exp_ready, ready_cyc, pulse_cyc, reads, writes, stall_left;
    misal = rv32 ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000);
    early = misal || (op > MAX_OP);
    // expectations pushed as the request is driven
    if (early) begin
      exp_flt_q.push_back({misal ? 2'd2 : 2'd3, addr});
    end else if (lfault) begin
      exp_flt_q.push_back({2'd0, addr});
    end else begin
      exp_wd_q.push_back(amo_model(op, rv32, mem, rs2));
      if (!abort_ww) begin
        if (sfault) exp_flt_q.push_back({2'd1, addr});
        else if (waddr != 6'd0)
          exp_wb_q.push_back({waddr, rv32 ? {{32{mem[31]}}, mem[31:0]} : mem});
      end
    end
    exp_ready = early ? 2 : (lfault ? 4 + stall : 7 + stall);
    exp_pulse = early || lfault || sfault || (waddr != 6'd0);

    check("idle_ready", 70'(bus.o_req_ready), 70'(1'b1));
    bus.i_req_valid      = 1'b1;
    bus.i_op             = op;
    bus.i_rv32           = rv32;
    bus.i_addr           = addr;
    bus.i_rs2            = rs2;
    bus.i_waddr          = waddr;
    // a response in the handshake cycle must be ignored
    bus.i_mem_resp_valid = early_resp;
    bus.i_mem_resp_fault = early_resp;
    bus.i_mem_resp_data  = {$urandom(), $urandom()};
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    cyc = 1; done = 1'b0; pend = 1'b0; pend_wr = 1'b0; pend_fault = 1'b0; pend_data = '0;
    ready_cyc = -1; pulse_cyc = -1; reads = 0; writes = 0; stall_left = stall;
    while (!done && cyc < 80) begin
      bus.i_mem_resp_valid = 1'b0;
      bus.i_mem_resp_fault = 1'b0;
      bus.i_mem_ready      = 1'b0;
      if (abort_ww && pend && pend_wr) begin
        // DUT is in WaitWrite: pull reset mid-operation
        rst_n = 1'b0;
        #1;
        check("abort_ready", 70'(bus.o_req_ready), 70'(1'b1));
        check("abort_busy", 70'(bus.o_busy), 70'(1'b0));
        check("abort_mem_valid", 70'(bus.o_mem_valid), 70'(1'b0));
        check("abort_wb_valid", 70'(bus.o_wb_valid), 70'(1'b0));
        check("abort_fault", 70'(bus.o_fault), 70'(1'b0));
        check("abort_state", 70'(dbg_state), 70'(3'd0));
        @(negedge clk);
        rst_n = 1'b1;
        // the late store response arrives after the abort
        bus.i_mem_resp_valid = 1'b1;
        bus.i_mem_resp_data  = {$urandom(), $urandom()};
        @(negedge clk);
        bus.i_mem_resp_valid = 1'b0;
        repeat (3) begin
          check("late_resp_idle", 70'({bus.o_req_ready, bus.o_mem_valid}), 70'(2'b10));
          @(negedge clk);
        end
        return;
      end
      if (pend) begin
        bus.i_mem_resp_valid = 1'b1;
        bus.i_mem_resp_fault = pend_fault;
        bus.i_mem_resp_data  = pend_data;
        pend = 1'b0;
      end
      if (bus.o_wb_valid || bus.o_fault) pulse_cyc = cyc;
      if (bus.o_req_ready) begin
        ready_cyc = cyc;
        done = 1'b1;
      end else begin
        check("busy", 70'(bus.o_busy), 70'(1'b1));
        if (bus.o_mem_valid) begin
          check("mem_addr", 70'(bus.o_mem_addr), 70'(addr));
          check("mem_size", 70'(bus.o_mem_size), 70'(rv32 ? 2'd2 : 2'd3));
          check("mem_write", 70'(bus.o_mem_write), 70'(reads > 0));
          if (stall_left > 0 && !bus.o_mem_write) begin
            check("stall_state", 70'(dbg_state), 70'(3'd1));
            stall_left--;
          end else begin
            bus.i_mem_ready = 1'b1;
            pend = 1'b1;
            pend_wr = bus.o_mem_write;
            if (bus.o_mem_write) begin
              writes++;
              pend_fault = sfault;
              pend_data  = {$urandom(), $urandom()};
            end else begin
              reads++;
              pend_fault = lfault;
              pend_data  = mem;
            end
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    bus.i_mem_ready = 1'b0;
    check("ready_cycle", 70'(ready_cyc), 70'(exp_ready));
    check("pulse_cycle", 70'(pulse_cyc), 70'(exp_pulse ? exp_ready - 1 : -1));
    check("read_count", 70'(reads), 70'(early ? 0 : 1));
    check("write_count", 70'(writes), 70'((early || lfault) ? 0 : 1));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_op = '0; bus.i_rv32 = 1'b0; bus.i_addr = '0;
    bus.i_rs2 = '0; bus.i_waddr = '0; bus.i_mem_ready = 1'b0;
    bus.i_mem_resp_valid = 1'b0; bus.i_mem_resp_data = '0; bus.i_mem_resp_fault = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_req_ready", 70'(bus.o_req_ready), 70'(1'b1));
    check("rst_busy", 70'(bus.o_busy), 70'(1'b0));
    check("rst_mem", 70'({bus.o_mem_valid, bus.o_mem_write, bus.o_mem_size}), 70'(0));
    check("rst_mem_addr", 70'(bus.o_mem_addr), 70'(0));
    check("rst_mem_wdata", 70'(bus.o_mem_wdata), 70'(0));
    check("rst_wb", {bus.o_wb_addr, bus.o_wb_data}, 70'(bus.o_wb_valid));
    check("rst_fault", 70'({bus.o_fault, bus.o_fault_code, bus.o_fault_addr}), 70'(0));
    check("rst_state", 70'(dbg_state), 70'(3'd0));
    rst_n = 1'b1;
    @(negedge clk);

    // AMOADD.D wrap to 0x8000...; wb x5 at cycle 6, ready at 7
    do_amo(4'd1, 1'b0, 64'h8000_0008, 64'd1, 6'd5, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // AMOMIN.W / AMOMINU.W signed vs unsigned word compare
    do_amo(4'd5, 1'b1, 64'h1004, 64'h0000_0001, 6'd3, 64'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_amo(4'd7, 1'b1, 64'h1004, 64'h0000_0001, 6'd3, 64'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // AMOMAX.D / AMOMAXU.D
    do_amo(4'd6, 1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE, 6'd7, 64'h5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_amo(4'd8, 1'b0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE, 6'd7, 64'h5, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // AMOSWAP.D misaligned: fault code 2 at cycle 1, no memory access
    do_amo(4'd0, 1'b0, 64'h1004, 64'h1234, 6'd1, 64'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // AMOOR.W load fault: code 0, no store
    do_amo(4'd4, 1'b1, 64'h3000, 64'hF0, 6'd9, 64'h0F, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    // AMOXOR.D store fault: code 1, no writeback
    do_amo(4'd2, 1'b0, 64'h3008, 64'hFF, 6'd9, 64'h0F, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    // AMOAND.D with memory not ready for 10 cycles in Read
    do_amo(4'd3, 1'b0, 64'h4010, 64'h00FF_00FF_00FF_00FF, 6'd12, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    // illegal op 9, and op 6 (illegal unless MIN/MAX is built in)
    do_amo(4'd9, 1'b0, 64'h5000, 64'h1, 6'd2, 64'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    do_amo(4'd6, 1'b0, 64'h5008, 64'h1, 6'd2, 64'h7, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // AMOADD.W wrap, waddr 0 (store, no wb), stray response in handshake cycle
    do_amo(4'd1, 1'b1, 64'h6004, 64'h0000_0002, 6'd0, 64'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    // reset while in WaitWrite
    do_amo(4'd1, 1'b1, 64'h7000, 64'h1, 6'd4, 64'h10, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    // random legal AMOs
    for (int i = 0; i < 8; i++) begin
      logic        rv;
      logic [63:0] a;
      rv = 1'($urandom_range(0, 1));
      a  = {$urandom(), $urandom()} & ~64'h7;
      if (rv) a[2] = 1'($urandom_range(0, 1));
      do_amo(4'($urandom_range(0, 4)), rv, a, {$urandom(), $urandom()}, 6'($urandom_range(0, 63)),
             {$urandom(), $urandom()}, 1'b0, 1'b0, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 70'(exp_wd_q.size() + exp_wb_q.size() + exp_flt_q.size()), 70'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
